// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing sequencer: op codes, FSM states, data width.
package alu_share_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ABSDIFF = 2'b01;
  localparam logic [1:0] OP_SUB     = 2'b10;
  localparam logic [1:0] OP_ADD2    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu.sv
// Team 4-bit combinational ALU: add, subtract and absolute difference with signed flags.
module ALU
  import alu_share_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              zero
);

  logic              add_sel;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] raw;

  always_comb begin
    add_sel  = (op == OP_ADD) || (op == OP_ADD2);
    // Subtract as a + ~b + 1 so both paths share one adder.
    b_eff    = add_sel ? b : ~b;
    raw      = a + b_eff + {{(DATA_W-1){1'b0}}, ~add_sel};
    overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
    zero     = (raw == '0);
    // Flags describe the raw difference; only the result is folded to a magnitude.
    result   = ((op == OP_ABSDIFF) && raw[DATA_W-1]) ? -raw : raw;
  end

endmodule

// File: rtl/alu_rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the side not granted last.
module alu_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = |valid;
    grant       = (&valid) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrating sequencer sharing one ALU between two valid/ready requesters, one op in flight.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_overflow,
  output logic              resp0_zero,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_overflow,
  output logic              resp1_zero,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e            state_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [1:0]        op_q;
  logic              gid_q, last_grant_q, ovf_q, zero_q;
  logic [3:0]        cnt_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow, alu_zero;
  logic              grant_valid, grant, accept, resp_hs;

  alu_rr_pick2 u_pick (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Operands reach the ALU only through registers so its inputs are stable while settling.
  ALU u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  always_comb begin
    req0_ready     = !rst && (state_q == IDLE) && grant_valid && !grant;
    req1_ready     = !rst && (state_q == IDLE) && grant_valid && grant;
    accept         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    resp0_valid    = (state_q == RESP) && !gid_q;
    resp1_valid    = (state_q == RESP) && gid_q;
    resp_hs        = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    resp0_result   = res_q;
    resp0_overflow = ovf_q;
    resp0_zero     = zero_q;
    resp1_result   = res_q;
    resp1_overflow = ovf_q;
    resp1_zero     = zero_q;
    busy           = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q          <= grant ? req1_a : req0_a;
            b_q          <= grant ? req1_b : req0_b;
            op_q         <= grant ? req1_op : req0_op;
            gid_q        <= grant;
            last_grant_q <= grant;
            cnt_q        <= CNT_LOAD;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q   <= alu_result;
            ovf_q   <= alu_overflow;
            zero_q  <= alu_zero;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (settle 1 and 4) checked against a behavioural model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index [d] selects the instance: 0 -> SETTLE_CYCLES=1, 1 -> SETTLE_CYCLES=4.
  logic       rst [2];
  logic       rv  [2][2];
  logic       rr  [2][2];
  logic [3:0] ra  [2][2];
  logic [3:0] rb  [2][2];
  logic [1:0] rop [2][2];
  logic       sv  [2][2];
  logic       sr  [2][2];
  logic [3:0] sres[2][2];
  logic       sovf[2][2];
  logic       szr [2][2];
  logic       busy[2];

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[0]),
    .req0_valid(rv[0][0]), .req0_ready(rr[0][0]), .req0_a(ra[0][0]), .req0_b(rb[0][0]),
    .req0_op(rop[0][0]),
    .req1_valid(rv[0][1]), .req1_ready(rr[0][1]), .req1_a(ra[0][1]), .req1_b(rb[0][1]),
    .req1_op(rop[0][1]),
    .resp0_valid(sv[0][0]), .resp0_ready(sr[0][0]), .resp0_result(sres[0][0]),
    .resp0_overflow(sovf[0][0]), .resp0_zero(szr[0][0]),
    .resp1_valid(sv[0][1]), .resp1_ready(sr[0][1]), .resp1_result(sres[0][1]),
    .resp1_overflow(sovf[0][1]), .resp1_zero(szr[0][1]),
    .busy(busy[0])
  );

  alu_share_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst[1]),
    .req0_valid(rv[1][0]), .req0_ready(rr[1][0]), .req0_a(ra[1][0]), .req0_b(rb[1][0]),
    .req0_op(rop[1][0]),
    .req1_valid(rv[1][1]), .req1_ready(rr[1][1]), .req1_a(ra[1][1]), .req1_b(rb[1][1]),
    .req1_op(rop[1][1]),
    .resp0_valid(sv[1][0]), .resp0_ready(sr[1][0]), .resp0_result(sres[1][0]),
    .resp0_overflow(sovf[1][0]), .resp0_zero(szr[1][0]),
    .resp1_valid(sv[1][1]), .resp1_ready(sr[1][1]), .resp1_result(sres[1][1]),
    .resp1_overflow(sovf[1][1]), .resp1_zero(szr[1][1]),
    .busy(busy[1])
  );

  // Reference: integer arithmetic, then wrap to 4 bits; flags come from the raw add/sub.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    int sa, sb, s, r;
    logic [3:0] raw, res;
    logic ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    s   = (op == 2'b01 || op == 2'b10) ? sa - sb : sa + sb;
    ovf = (s > 7) || (s < -8);
    raw = s[3:0];
    r   = int'($signed(raw));
    if (op == 2'b01 && r < 0) r = -r;
    res = r[3:0];
    return {res, ovf, (raw == 4'd0)};
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    rv[d][0] = 1'b0; rv[d][1] = 1'b0; sr[d][0] = 1'b0; sr[d][1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst[d] = 1'b0;
  endtask

  // Present an op and hold it until accepted; returns at the negedge after the accept edge.
  task automatic issue(input int d, input int w, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, output bit ok);
    ok = 1'b0;
    rv[d][w] = 1'b1; ra[d][w] = a; rb[d][w] = b; rop[d][w] = op;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (rr[d][w]) ok = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rv[d][w] = 1'b0;
  endtask

  // Wait (bounded) for the response; lat counts rising edges after the accept edge.
  task automatic collect(input int d, input int w, output int lat, output logic [3:0] res,
                         output logic ovf, output logic zero);
    lat = 0;
    while (!sv[d][w] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = sres[d][w]; ovf = sovf[d][w]; zero = szr[d][w];
  endtask

  task automatic respond(input int d, input int w);
    sr[d][w] = 1'b1;
    @(posedge clk); @(negedge clk);
    sr[d][w] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      rst[d] = 1'b1;
      rv[d][0] = 1'b1; rv[d][1] = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({rr[d][1], rr[d][0], sv[d][1], sv[d][0], busy[d]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got rdy=%b%b rv=%b%b busy=%b required all 0", d,
                 rr[d][1], rr[d][0], sv[d][1], sv[d][0], busy[d]);
      end
      n_checks++;
      if ({sres[d][0], sovf[d][0], szr[d][0]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_resp[%0d]: got %h/%b/%b required 0/0/0", d, sres[d][0],
                 sovf[d][0], szr[d][0]);
      end
      rv[d][0] = 1'b0; rv[d][1] = 1'b0;
      rst[d] = 1'b0;
    end
  endtask

  task automatic test_directed();
    int tw[5]   = '{0, 1, 1, 0, 0};
    int ta[5]   = '{7, 3, 3, 5, 0};
    int tb[5]   = '{1, 5, 5, 5, 8};
    int top[5]  = '{0, 1, 2, 2, 1};
    int tres[5] = '{8, 2, 14, 0, 8};
    int tovf[5] = '{1, 0, 0, 0, 1};
    int tz[5]   = '{0, 0, 0, 1, 0};
    bit ok;
    int lat, w;
    logic [3:0] res;
    logic ovf, zero;
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      w = tw[i];
      if (i == 1) sr[0][1] = 1'b1;  // response ready already high before valid
      issue(0, w, 4'(ta[i]), 4'(tb[i]), 2'(top[i]), ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dir%0d_accept: got 0 required 1", i); end
      collect(0, w, lat, res, ovf, zero);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL dir%0d_latency: got %0d required 1", i, lat); end
      n_checks++;
      if ({res, ovf, zero} !== {4'(tres[i]), 1'(tovf[i]), 1'(tz[i])}) begin
        n_fail++;
        $display("FAIL dir%0d_result: got %h/%b/%b required %h/%0d/%0d", i, res, ovf, zero,
                 tres[i], tovf[i], tz[i]);
      end
      n_checks++;
      if (sv[0][1-w] !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_other_valid: got %b required 0", i, sv[0][1-w]);
      end
      if (i == 1) begin
        @(posedge clk); @(negedge clk);
        sr[0][1] = 1'b0;
      end else begin
        respond(0, w);
      end
      n_checks++;
      if ({busy[0], sv[0][w]} !== 2'b00) begin
        n_fail++; $display("FAIL dir%0d_idle: got busy=%b valid=%b required 0/0", i, busy[0], sv[0][w]);
      end
    end
  endtask

  task automatic test_arbitration();
    int w, n, bad;
    do_reset(0);
    ra[0][0] = 4'd2; rb[0][0] = 4'd3; rop[0][0] = 2'b00;
    ra[0][1] = 4'd4; rb[0][1] = 4'd1; rop[0][1] = 2'b10;
    for (int k = 0; k < 3; k++) begin
      w = (k == 1) ? 1 : 0;
      rv[0][0] = 1'b1; rv[0][1] = 1'b1;
      #1;
      n_checks++;
      if ({rr[0][1], rr[0][0]} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL arb%0d_grant: got ready=%b%b required winner %0d", k,
                           rr[0][1], rr[0][0], w);
      end
      @(posedge clk); @(negedge clk);
      rv[0][w] = 1'b0;
      bad = 0; n = 0;
      while (!sv[0][w] && n < 20) begin
        if (rr[0][0] || rr[0][1]) bad++;
        @(negedge clk);
        n++;
      end
      if (rr[0][0] || rr[0][1]) bad++;
      n_checks++;
      if (bad !== 0 || sv[0][w] !== 1'b1) begin
        n_fail++; $display("FAIL arb%0d_busy_ready: got %0d ready cycles, valid=%b required 0/1",
                           k, bad, sv[0][w]);
      end
      respond(0, w);
    end
    rv[0][1] = 1'b0;
    @(posedge clk); @(negedge clk);
    respond(0, 1);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat, bad;
    logic [3:0] res;
    logic ovf, zero;
    do_reset(0);
    issue(0, 0, 4'd6, 4'd3, 2'b10, ok);
    rv[0][1] = 1'b1; ra[0][1] = 4'd1; rb[0][1] = 4'd1; rop[0][1] = 2'b00;
    collect(0, 0, lat, res, ovf, zero);
    n_checks++;
    if ({res, ovf, zero} !== 6'b0011_0_0) begin
      n_fail++; $display("FAIL bp_result: got %h/%b/%b required 3/0/0", res, ovf, zero);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (sv[0][0] !== 1'b1 || sres[0][0] !== res || sovf[0][0] !== ovf || szr[0][0] !== zero ||
          busy[0] !== 1'b1 || rr[0][1] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles required 0", bad); end
    respond(0, 0);
    #1;
    n_checks++;
    if ({busy[0], rr[0][1]} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got busy=%b ready1=%b required 0/1", busy[0], rr[0][1]);
    end
    @(posedge clk); @(negedge clk);
    rv[0][1] = 1'b0;
    collect(0, 1, lat, res, ovf, zero);
    n_checks++;
    if (res !== 4'd2) begin n_fail++; $display("FAIL bp_second: got %h required 2", res); end
    respond(0, 1);
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    int bad, lat;
    logic [3:0] res;
    logic ovf, zero;
    do_reset(1);
    issue(1, 1, 4'd2, 4'd2, 2'b00, ok);
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b0;
    n_checks++;
    if ({busy[1], sv[1][0], sv[1][1]} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_idle: got busy=%b valid=%b%b required 0/00", busy[1],
                         sv[1][1], sv[1][0]);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (sv[1][0] || sv[1][1] || busy[1]) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_noresp: got %0d bad cycles required 0", bad); end
    rv[1][0] = 1'b1; ra[1][0] = 4'd9; rb[1][0] = 4'd3; rop[1][0] = 2'b01;
    rv[1][1] = 1'b1; ra[1][1] = 4'd1; rb[1][1] = 4'd1; rop[1][1] = 2'b00;
    #1;
    n_checks++;
    if ({rr[1][1], rr[1][0]} !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_tie: got ready=%b%b required 01", rr[1][1], rr[1][0]);
    end
    @(posedge clk); @(negedge clk);
    rv[1][0] = 1'b0; rv[1][1] = 1'b0;
    collect(1, 0, lat, res, ovf, zero);
    n_checks++;
    if (lat !== 4 || {res, ovf, zero} !== model(4'd9, 4'd3, 2'b01)) begin
      n_fail++; $display("FAIL rst_mid_op: got lat=%0d %h/%b/%b required lat=4 %h", lat, res, ovf,
                         zero, model(4'd9, 4'd3, 2'b01));
    end
    respond(1, 0);
  endtask

  task automatic test_random(input int d);
    bit pend[2];
    logic [3:0] pa[2], pb[2];
    logic [1:0] pop[2];
    int last, w, lat, bad, stall;
    logic [5:0] exp;
    logic [3:0] res;
    logic ovf, zero;
    do_reset(d);
    last = 1; pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1 || (r == 1 && !pend[0]))) begin
          pend[r] = 1'b1;
          pa[r] = 4'($urandom); pb[r] = 4'($urandom); pop[r] = 2'($urandom);
        end
      end
      for (int r = 0; r < 2; r++) begin
        rv[d][r] = pend[r]; ra[d][r] = pa[r]; rb[d][r] = pb[r]; rop[d][r] = pop[r];
      end
      w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      #1;
      n_checks++;
      if ({rr[d][1], rr[d][0]} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rnd%0d_%0d_grant: got ready=%b%b required winner %0d", d, it,
                           rr[d][1], rr[d][0], w);
      end
      @(posedge clk); @(negedge clk);
      rv[d][w] = 1'b0; pend[w] = 1'b0; last = w;
      exp = model(pa[w], pb[w], pop[w]);
      collect(d, w, lat, res, ovf, zero);
      n_checks++;
      if (lat !== settle_of(d) || {res, ovf, zero} !== exp || sv[d][1-w] !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_%0d_resp: got lat=%0d %h/%b/%b other=%b required lat=%0d %h/%b/%b",
                 d, it, lat, res, ovf, zero, sv[d][1-w], settle_of(d), exp[5:2], exp[1], exp[0]);
      end
      bad = 0;
      stall = $urandom_range(3, 0);
      repeat (stall) begin
        @(negedge clk);
        if (!sv[d][w] || sres[d][w] !== res || rr[d][0] || rr[d][1]) bad++;
      end
      respond(d, w);
      n_checks++;
      if (bad !== 0 || busy[d] !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_%0d_hold: got bad=%0d busy=%b required 0/0", d, it, bad,
                           busy[d]);
      end
    end
    rv[d][0] = 1'b0; rv[d][1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        rv[d][r] = 1'b0; ra[d][r] = '0; rb[d][r] = '0; rop[d][r] = '0; sr[d][r] = 1'b0;
      end
    end
    test_reset();
    test_directed();
    test_arbitration();
    test_backpressure();
    test_reset_mid_exec();
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
